uart_engine: RTL and testbench

UART_ENGINE -- requirements
Module: uart_engine

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_engine.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART engine: FSM state enums,
// parity_mode encodings, minimum divider, parity helper. UART_PARITY_EN adds PARITY states.
package uart_pkg;

    localparam int MIN_DIV = 3;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_e;
`endif

    // Parity bit over a zero-extended word: even -> XOR, odd -> XNOR.
    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic       odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO holding received UART words.
// Ports: clk, rst, push_i/data_i (write), pop_i (read), full_o, empty_o, data_o (head word).
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + (AW+1)'(1);
        if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_engine.sv
// Full-duplex UART with TX/RX FSMs, RX FIFO and sticky error flags. Optional parity via UART_PARITY_EN.
// Ports: clk, rst, divider, [parity_mode], rxd, txd, tx_*, rx_*, rx_*_err/overrun, err_clear.
module uart_engine
    import uart_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int DIV_WIDTH     = 12,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] divider,
`ifdef UART_PARITY_EN
    input  logic [1:0]           parity_mode,
`endif
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 err_clear
);

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic [DIV_WIDTH-1:0] div_eff;

    assign div_eff = (divider < DIV_WIDTH'(MIN_DIV)) ?
                     DIV_WIDTH'(MIN_DIV) : divider;

    // ---------------- TX ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic                 tx_stop_q, tx_stop_d;
    logic                 tx_tick;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
    logic                 tx_paren_q, tx_paren_d;
`endif

    assign tx_tick  = (tx_cnt_q == tx_div_q);
    assign tx_ready = (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
        tx_paren_d = tx_paren_q;
`endif
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + ONE;
        end
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_shift_d = tx_data;
                    tx_div_d   = div_eff;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_stop_d  = 1'b0;
                    tx_state_d = TX_START;
`ifdef UART_PARITY_EN
                    tx_paren_d = (parity_mode == PAR_EVEN) ||
                                 (parity_mode == PAR_ODD);
                    tx_par_d   = calc_parity(8'(tx_data),
                                             parity_mode == PAR_ODD);
`endif
                end
            end
            TX_START: begin
                if (tx_tick) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_bit_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = tx_paren_q ? TX_PARITY : TX_STOP;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_tick) tx_state_d = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_stop_q == 1'(STOP_BITS - 1)) begin
                        tx_stop_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state_q)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shift_q[0];
`ifdef UART_PARITY_EN
            TX_PARITY: txd = tx_par_q;
`endif
            default:   txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            tx_paren_q <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            tx_paren_q <= tx_paren_d;
`endif
        end
    end

    // ---------------- RX ----------------
    logic                 rx_s1_q, rx_s2_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic                 rx_tick;
    logic                 rx_push;
    logic                 ferr_set;
    logic                 perr_set;
`ifdef UART_PARITY_EN
    logic                 rx_paren_q, rx_paren_d;
    logic                 rx_odd_q, rx_odd_d;
    logic                 rx_pbad_q, rx_pbad_d;
`endif

    assign rx_tick = (rx_cnt_q == rx_div_q);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        perr_set   = 1'b0;
`ifdef UART_PARITY_EN
        rx_paren_d = rx_paren_q;
        rx_odd_d   = rx_odd_q;
        rx_pbad_d  = rx_pbad_q;
`endif
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                    rx_div_d   = div_eff;
`ifdef UART_PARITY_EN
                    rx_paren_d = (parity_mode == PAR_EVEN) ||
                                 (parity_mode == PAR_ODD);
                    rx_odd_d   = (parity_mode == PAR_ODD);
`endif
                end
            end
            RX_START: begin
                // Half a bit in: a high line means the low was a glitch.
                if (rx_cnt_q == (rx_div_q >> 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
                    rx_pbad_d  = 1'b0;
`endif
                end else begin
                    rx_cnt_d = rx_cnt_q + ONE;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + ONE;
                if (rx_tick) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 4'd1;
                    if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state_d = rx_paren_q ? RX_PARITY : RX_STOP;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + ONE;
                if (rx_tick) begin
                    rx_pbad_d  = rx_s2_q !=
                                 calc_parity(8'(rx_shift_q), rx_odd_q);
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                // Only the first stop bit is checked; a second one
                // is just idle line as far as RX is concerned.
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + ONE;
                if (rx_tick) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
                        perr_set = rx_pbad_q;
                        rx_push  = ~rx_pbad_q;
`else
                        rx_push  = 1'b1;
`endif
                    end else begin
                        ferr_set   = 1'b1;
                        rx_state_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
`ifdef UART_PARITY_EN
            rx_paren_q <= 1'b0;
            rx_odd_q   <= 1'b0;
            rx_pbad_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q    <= rxd;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
`ifdef UART_PARITY_EN
            rx_paren_q <= rx_paren_d;
            rx_odd_q   <= rx_odd_d;
            rx_pbad_q  <= rx_pbad_d;
`endif
        end
    end

    // ---------------- FIFO and flags ----------------
    logic fifo_full;
    logic fifo_empty;
    logic rx_pop;
    logic ovr_set;
    logic ovr_q, ovr_d;
    logic ferr_q, ferr_d;
    logic perr_q, perr_d;

    assign rx_valid = ~fifo_empty;
    assign rx_pop   = rx_valid & rx_ready;
    assign ovr_set  = rx_push & fifo_full & ~rx_pop;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (rx_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (rx_data)
    );

    // Set beats clear when both happen in one cycle.
    always_comb begin
        ovr_d  = ovr_set  ? 1'b1 : (err_clear ? 1'b0 : ovr_q);
        ferr_d = ferr_set ? 1'b1 : (err_clear ? 1'b0 : ferr_q);
        perr_d = perr_set ? 1'b1 : (err_clear ? 1'b0 : perr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            perr_q <= perr_d;
        end
    end

    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_engine.sv
// Directed self-checking bench for uart_engine (default parameters).
// Parity scenario is built only when UART_PARITY_EN is defined.
module tb_uart_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] divider = 12'd3;
`ifdef UART_PARITY_EN
    logic [1:0]  parity_mode = 2'b00;
`endif
    logic        rxd;
    logic        rxd_drv = 1'b1;
    logic        loop = 1'b0;
    logic        txd;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_overrun;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        err_clear = 1'b0;

    int checks = 0;
    int errors = 0;

    assign rxd = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    uart_engine dut (
        .clk           (clk),
        .rst           (rst),
        .divider       (divider),
`ifdef UART_PARITY_EN
        .parity_mode   (parity_mode),
`endif
        .rxd           (rxd),
        .txd           (txd),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_overrun    (rx_overrun),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .err_clear     (err_clear)
    );

    task automatic send_word(input logic [7:0] w);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_wait tx_ready=%b want 1", tx_ready);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_wait tx_ready=%b want 1", tx_ready);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 5;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got=%b want 1", txd); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_txrdy got=%b want 1", tx_ready); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rxv got=%b want 0", rx_valid); end
        if ({rx_overrun, rx_frame_err} !== 2'b00) begin
            errors++; $display("FAIL rst_flags got=%b%b want 00", rx_overrun, rx_frame_err);
        end
        if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr got=%b want 0", rx_parity_err); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_tx_a5();
        logic [9:0] f;
        logic       exp_txd;
        f = {1'b1, 8'hA5, 1'b0};
        loop = 1'b0;
        rxd_drv = 1'b1;
        divider = 12'd3;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        // Inputs change after acceptance; frame must not follow them.
        tx_valid = 1'b0;
        tx_data = 8'h00;
        divider = 12'd10;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            exp_txd = (k < 40) ? f[k/4] : 1'b1;
            checks += 2;
            if (txd !== exp_txd) begin
                errors++; $display("FAIL tx_a5_bit k=%0d got=%b want %b", k, txd, exp_txd);
            end
            if (tx_ready !== (k == 40)) begin
                errors++; $display("FAIL tx_a5_rdy k=%0d got=%b want %b", k, tx_ready, k == 40);
            end
        end
        divider = 12'd3;
        @(posedge clk); #1;
    endtask

    task automatic test_min_divider();
        divider = 12'd1;
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3 || k == 4) begin
                checks++;
                if (txd !== (k == 4)) begin
                    errors++; $display("FAIL mindiv_txd k=%0d got=%b want %b", k, txd, k == 4);
                end
            end
            if (k == 39 || k == 40) begin
                checks++;
                if (tx_ready !== (k == 40)) begin
                    errors++; $display("FAIL mindiv_rdy k=%0d got=%b want %b", k, tx_ready, k == 40);
                end
            end
        end
        divider = 12'd3;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{8'h00, 8'hFF, 8'h5A};
        loop = 1'b1;
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_word(exp[i]);
        wait_tx_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (rx_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_valid i=%0d got=%b want 1", i, rx_valid);
            end
            if (rx_data !== exp[i]) begin
                errors++; $display("FAIL b2b_data i=%0d got=%h want %h", i, rx_data, exp[i]);
            end
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
        @(negedge clk);
        checks += 2;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%b want 0", rx_valid); end
        if ({rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
            errors++; $display("FAIL b2b_flags got=%b%b%b want 000", rx_overrun, rx_frame_err, rx_parity_err);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        loop = 1'b1;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(exp[i]);
        wait_tx_idle();
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b want 0", rx_overrun); end
        send_word(exp[4]);
        wait_tx_idle();
        checks++;
        if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b want 1", rx_overrun); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp[i]) begin
                errors++; $display("FAIL ovr_data i=%0d got=%b/%h want 1/%h", i, rx_valid, rx_data, exp[i]);
            end
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drop got=%b want 0", rx_valid); end
        @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want 0", rx_overrun); end
    endtask

    task automatic test_break();
        loop = 1'b0;
        rxd_drv = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        checks += 2;
        if (rx_frame_err !== 1'b1) begin errors++; $display("FAIL brk_ferr got=%b want 1", rx_frame_err); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL brk_nopush got=%b want 0", rx_valid); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL brk_hold got=%b want 0", rx_frame_err); end
        rxd_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            errors++; $display("FAIL brk_release got=%b/%b want 0/0", rx_valid, rx_frame_err);
        end
        loop = 1'b1;
        send_word(8'h3C);
        wait_tx_idle();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
            errors++; $display("FAIL brk_recover got=%b/%h want 1/3c", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic test_glitch();
        loop = 1'b0;
        rxd_drv = 1'b1;
        divider = 12'd15;
        repeat (4) @(posedge clk);
        #1;
        rxd_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rxd_drv = 1'b1;
        repeat (250) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            errors++; $display("FAIL glitch got=%b/%b want 0/0", rx_valid, rx_frame_err);
        end
        divider = 12'd3;
    endtask

    task automatic test_reset_mid_tx();
        loop = 1'b1;
        send_word(8'h00);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (tx_ready !== 1'b0 || txd !== 1'b0) begin
            errors++; $display("FAIL midtx_busy got=%b/%b want 0/0", tx_ready, txd);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (txd !== 1'b1 || tx_ready !== 1'b1) begin
            errors++; $display("FAIL midtx_rst got=%b/%b want 1/1", txd, tx_ready);
        end
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
            errors++; $display("FAIL midtx_rx got=%b/%b want 0/0", rx_valid, rx_frame_err);
        end
        loop = 1'b0;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic [10:0] fr;
        loop = 1'b0;
        rxd_drv = 1'b1;
        parity_mode = 2'b10;
        @(posedge clk); #1;
        // 8'h03 odd parity needs 1; send 0.
        fr = {1'b1, 1'b0, 8'h03, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_drv = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks += 2;
        if (rx_parity_err !== 1'b1) begin errors++; $display("FAIL par_err got=%b want 1", rx_parity_err); end
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL par_drop got=%b want 0", rx_valid); end
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        fr = {1'b1, 1'b1, 8'h03, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rxd_drv = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h03 || rx_parity_err !== 1'b0) begin
            errors++; $display("FAIL par_good got=%b/%h/%b want 1/03/0", rx_valid, rx_data, rx_parity_err);
        end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        loop = 1'b1;
        send_word(8'h5A);
        wait_tx_idle();
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_parity_err !== 1'b0) begin
            errors++; $display("FAIL par_loop got=%b/%h/%b want 1/5a/0", rx_valid, rx_data, rx_parity_err);
        end
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        loop = 1'b0;
        parity_mode = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_tx_a5();
        test_min_divider();
        test_back_to_back();
        test_overrun();
        test_break();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
